// File: rtl/serial_link_pkg.sv
// Shared types and frame constants for the 8N1 serial link.
package serial_link_pkg;

  localparam int unsigned FRAME_BITS = 10;
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned BIT_W      = $clog2(DATA_BITS);

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

endpackage

// File: rtl/serial_link_if.sv
// Processor-side parallel port bundle; member names match the processor I/O names.
interface serial_link_if;
  import serial_link_pkg::*;

  logic                 load;
  logic [DATA_BITS-1:0] data_bus_out;
  logic                 transmit_enable;
  logic [DATA_BITS-1:0] data_bus_in;
  logic                 character_received;
  logic                 character_sent;
  logic                 framing_error;

  modport master (
    output load, data_bus_out, transmit_enable,
    input  data_bus_in, character_received, character_sent, framing_error
  );

  modport slave (
    input  load, data_bus_out, transmit_enable,
    output data_bus_in, character_received, character_sent, framing_error
  );

endinterface

// File: rtl/serial_rx.sv
// 8N1 receiver: input synchroniser, mid-bit sampling FSM and received-byte flags.
module serial_rx
  import serial_link_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] data_bus_in,
  output logic                 character_received,
  output logic                 framing_error
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   line;
  rx_state_t              state;
  logic [BAUD_W-1:0]      baud;
  logic [BIT_W-1:0]       bit_cnt;
  logic [DATA_BITS-1:0]   shift;

  // Resets to idle-high so a reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!rst_n) sync <= '1;
    else        sync <= {sync[SYNC_STAGES-2:0], serial_in};
  end

  assign line = sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state              <= RX_IDLE;
      baud               <= '0;
      bit_cnt            <= '0;
      shift              <= '0;
      data_bus_in        <= '0;
      character_received <= 1'b0;
      framing_error      <= 1'b0;
    end else begin
      case (state)
        RX_IDLE: begin
          baud <= '0;
          if (!line) state <= RX_START;
        end
        // Re-check at mid start bit to reject short glitches.
        RX_START: begin
          if (baud == BAUD_HALF) begin
            baud    <= '0;
            bit_cnt <= '0;
            if (line) begin
              state <= RX_IDLE;
            end else begin
              character_received <= 1'b0;
              state              <= RX_DATA;
            end
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        RX_DATA: begin
          if (baud == BAUD_LAST) begin
            baud    <= '0;
            shift   <= {line, shift[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + BIT_W'(1);
            if (bit_cnt == BIT_LAST) state <= RX_STOP;
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        RX_STOP: begin
          if (baud == BAUD_LAST) begin
            baud <= '0;
            if (line) begin
              data_bus_in        <= shift;
              character_received <= 1'b1;
              framing_error      <= 1'b0;
              state              <= RX_IDLE;
            end else begin
              framing_error <= 1'b1;
              state         <= RX_WAIT_HIGH;
            end
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        // A low stop bit may be a break; wait for the line to recover.
        RX_WAIT_HIGH: begin
          baud <= '0;
          if (line) state <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/serial_link.sv
// Full-duplex 8N1 transceiver between the processor parallel ports and the link wire.
module serial_link
  import serial_link_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic          clk_clk,
  input  logic          reset_reset_n,
  serial_link_if.slave  bus,
  input  logic          serial_in,
  output logic          serial_out
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  logic                 te_q;
  logic                 te_prev;
  logic                 te_rise;
  logic [DATA_BITS-1:0] hold;
  logic [DATA_BITS-1:0] shift;
  logic [BAUD_W-1:0]    baud;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 character_sent;
  tx_state_t            state;

  // Edge detect on the registered enable plus the processor holding register.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      te_q    <= 1'b0;
      te_prev <= 1'b0;
      hold    <= '0;
    end else begin
      te_q    <= bus.transmit_enable;
      te_prev <= te_q;
      if (bus.load) hold <= bus.data_bus_out;
    end
  end

  assign te_rise = te_q & ~te_prev;

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state          <= TX_IDLE;
      baud           <= '0;
      bit_cnt        <= '0;
      shift          <= '0;
      serial_out     <= 1'b1;
      character_sent <= 1'b0;
    end else begin
      case (state)
        // Same-cycle load bypasses the holding register so the fresh byte goes out.
        TX_IDLE: begin
          baud <= '0;
          if (te_rise) begin
            shift      <= bus.load ? bus.data_bus_out : hold;
            serial_out <= 1'b0;
            state      <= TX_START;
          end
        end
        TX_START: begin
          if (baud == BAUD_LAST) begin
            baud           <= '0;
            bit_cnt        <= '0;
            serial_out     <= shift[0];
            shift          <= {1'b0, shift[DATA_BITS-1:1]};
            character_sent <= 1'b0;
            state          <= TX_DATA;
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        TX_DATA: begin
          if (baud == BAUD_LAST) begin
            baud    <= '0;
            bit_cnt <= bit_cnt + BIT_W'(1);
            if (bit_cnt == BIT_LAST) begin
              serial_out <= 1'b1;
              state      <= TX_STOP;
            end else begin
              serial_out <= shift[0];
              shift      <= {1'b0, shift[DATA_BITS-1:1]};
            end
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        TX_STOP: begin
          if (baud == BAUD_LAST) begin
            baud           <= '0;
            character_sent <= 1'b1;
            state          <= TX_IDLE;
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

  assign bus.character_sent = character_sent;

  serial_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .SYNC_STAGES  (SYNC_STAGES)
  ) u_rx (
    .clk                (clk_clk),
    .rst_n              (reset_reset_n),
    .serial_in          (serial_in),
    .data_bus_in        (bus.data_bus_in),
    .character_received (bus.character_received),
    .framing_error      (bus.framing_error)
  );

endmodule

// File: tb/tb_serial_link.sv
// Directed, table-driven bench for serial_link at 16 clocks per bit.
module tb_serial_link;

  localparam int unsigned CPB = 16;

  typedef struct {
    int         mode;     // 0: no load, 1: load with enable, 2: load on the rise cycle
    logic [7:0] data;
    logic [9:0] frame;    // bit i is the i-th transmitted bit
    bit         inject;
  } tx_vec_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       cr_before;
    bit         glitch_first;
    logic [7:0] exp_dbi;
    logic       exp_cr;
    logic       exp_fe;
  } rx_vec_t;

  logic clk;
  logic rst_n;
  logic rx_drv;
  logic loopback;
  logic serial_in;
  logic serial_out;
  int   checks;
  int   passed;

  tx_vec_t tx_tab [4];
  rx_vec_t rx_tab [4];

  serial_link_if bus ();

  serial_link #(
    .CLKS_PER_BIT (CPB),
    .SYNC_STAGES  (2)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .bus           (bus),
    .serial_in     (serial_in),
    .serial_out    (serial_out)
  );

  assign serial_in = loopback ? serial_out : rx_drv;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tx_run(input int mode, input logic [7:0] d, input logic [9:0] frame, input bit inject);
    int bad [10];
    int t;
    int lows;
    foreach (bad[k]) bad[k] = 0;
    @(negedge clk);
    bus.transmit_enable = 1'b1;
    bus.load = (mode == 1);
    if (mode != 0) bus.data_bus_out = d;
    @(negedge clk);
    bus.load = (mode == 2);
    @(negedge clk);
    bus.load = 1'b0;
    t = 0;
    while (serial_out !== 1'b0 && t < 8) begin
      @(negedge clk);
      t++;
    end
    check("tx_start_seen", 8'(serial_out), 8'h00);
    for (int c = 0; c < 160; c++) begin
      if (serial_out !== frame[c/16]) bad[c/16]++;
      if (c == 159) check("tx_sent_low_before_end", 8'(bus.character_sent), 8'h00);
      if (c == 2) bus.transmit_enable = 1'b0;
      if (inject && c == 40) begin
        bus.load = 1'b1;
        bus.data_bus_out = 8'hFF;
        bus.transmit_enable = 1'b1;
      end
      if (inject && c == 41) bus.load = 1'b0;
      if (inject && c == 44) bus.transmit_enable = 1'b0;
      @(negedge clk);
    end
    check("tx_sent_high_at_end", 8'(bus.character_sent), 8'h01);
    for (int b = 0; b < 10; b++) check($sformatf("tx_bit%0d_bad_cycles", b), 8'(bad[b]), 8'h00);
    if (inject) begin
      lows = 0;
      repeat (40) begin
        if (serial_out !== 1'b1) lows++;
        @(negedge clk);
      end
      check("tx_no_second_frame", 8'(lows), 8'h00);
    end
  endtask

  task automatic rx_send(input logic [7:0] d, input logic stop, input logic cr_before);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < 160; i++) begin
      if (i == 4) check("rx_cr_before_confirm", 8'(bus.character_received), 8'(cr_before));
      if (i == 14) check("rx_cr_cleared_on_start", 8'(bus.character_received), 8'h00);
      rx_drv = f[i/16];
      @(negedge clk);
    end
    rx_drv = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    checks = 0;
    passed = 0;
    rst_n = 1'b0;
    rx_drv = 1'b1;
    loopback = 1'b0;
    bus.load = 1'b0;
    bus.data_bus_out = 8'h00;
    bus.transmit_enable = 1'b0;

    tx_tab[0] = '{1, 8'hA5, 10'b1101001010, 1'b0};
    tx_tab[1] = '{1, 8'h3C, 10'b1001111000, 1'b1};
    tx_tab[2] = '{0, 8'h00, 10'b1111111110, 1'b0};
    tx_tab[3] = '{2, 8'h81, 10'b1100000010, 1'b0};

    rx_tab[0] = '{8'h3C, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0};
    rx_tab[1] = '{8'h77, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1};
    rx_tab[2] = '{8'h01, 1'b1, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
    rx_tab[3] = '{8'hC3, 1'b1, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    check("reset_serial_out", 8'(serial_out), 8'h01);
    check("reset_data_bus_in", bus.data_bus_in, 8'h00);
    check("reset_char_received", 8'(bus.character_received), 8'h00);
    check("reset_char_sent", 8'(bus.character_sent), 8'h00);
    check("reset_framing_error", 8'(bus.framing_error), 8'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 4; i++)
      tx_run(tx_tab[i].mode, tx_tab[i].data, tx_tab[i].frame, tx_tab[i].inject);

    for (int i = 0; i < 4; i++) begin
      if (rx_tab[i].glitch_first) begin
        rx_drv = 1'b0;
        repeat (5) @(negedge clk);
        rx_drv = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_dbi", bus.data_bus_in, 8'h3C);
        check("glitch_cr", 8'(bus.character_received), 8'h00);
        check("glitch_fe", 8'(bus.framing_error), 8'h01);
      end
      rx_send(rx_tab[i].data, rx_tab[i].stop, rx_tab[i].cr_before);
      check($sformatf("rx%0d_dbi", i), bus.data_bus_in, rx_tab[i].exp_dbi);
      check($sformatf("rx%0d_cr", i), 8'(bus.character_received), 8'(rx_tab[i].exp_cr));
      check($sformatf("rx%0d_fe", i), 8'(bus.framing_error), 8'(rx_tab[i].exp_fe));
    end

    // Simultaneous transmit and receive.
    fork
      tx_run(1, 8'h96, 10'b1100101100, 1'b0);
      rx_send(8'h69, 1'b1, 1'b1);
    join
    check("duplex_rx_dbi", bus.data_bus_in, 8'h69);
    check("duplex_rx_cr", 8'(bus.character_received), 8'h01);

    // Reset in the middle of both a TX and an RX frame.
    bus.load = 1'b1;
    bus.data_bus_out = 8'hF0;
    bus.transmit_enable = 1'b1;
    rx_drv = 1'b0;
    @(negedge clk);
    bus.load = 1'b0;
    repeat (60) @(negedge clk);
    rx_drv = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.transmit_enable = 1'b0;
    check("midreset_serial_out", 8'(serial_out), 8'h01);
    check("midreset_dbi", bus.data_bus_in, 8'h00);
    check("midreset_cr", 8'(bus.character_received), 8'h00);
    check("midreset_cs", 8'(bus.character_sent), 8'h00);
    check("midreset_fe", 8'(bus.framing_error), 8'h00);
    repeat (20) @(negedge clk);
    check("midreset_line_idle", 8'(serial_out), 8'h01);

    // Holding register was cleared by reset.
    tx_run(0, 8'h00, 10'b1000000000, 1'b0);

    loopback = 1'b1;
    tx_run(1, 8'h5A, 10'b1010110100, 1'b0);
    repeat (5) @(negedge clk);
    check("loopback_dbi", bus.data_bus_in, 8'h5A);
    check("loopback_cr", 8'(bus.character_received), 8'h01);
    check("loopback_fe", 8'(bus.framing_error), 8'h00);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
